cmp_offset_collector: RTL and testbench

- Sits directly downstream of the comparator offset finder in the FLASH_ADC calibration path.
- Edge-detects the finder's per-comparator `rdy` pulse and captures the settled 16-bit SAR DAC code into a 32-entry table.
- Converts each code to a signed offset against the ideal ladder threshold and tracks the min/max offset.
- Once all comparators are captured, streams the table out over a valid/ready interface for trim loading or readout.

---
 rtl/cmp_cal_pkg.sv | 44 ++++
 rtl/cmp_offset_table.sv | 39 +++
 rtl/cmp_offset_collector.sv | 161 ++++++++++++++++
 tb/tb_cmp_offset_collector.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/cmp_cal_pkg.sv
// Shared constants, state encoding and offset arithmetic for the comparator
// offset collector that sits behind the FLASH_ADC offset finder.
package cmp_cal_pkg;

  localparam int N_CMP = 32;
  localparam int BITS  = 16;
  localparam int IW    = $clog2(N_CMP);
  localparam int OFF_W = BITS + 1;

  localparam logic [BITS-1:0] NOM_BASE = 16'h0400;
  localparam logic [BITS-1:0] NOM_STEP = 16'h0800;

  // Extremes of the signed offset range, used to seed the min/max trackers
  localparam logic [OFF_W-1:0] OFF_MOST_POS = {1'b0, {BITS{1'b1}}};
  localparam logic [OFF_W-1:0] OFF_MOST_NEG = {1'b1, {BITS{1'b0}}};

  localparam logic [IW-1:0] LAST_IDX = IW'(N_CMP - 1);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DONE    = 2'd1,
    DUMP    = 2'd2
  } cal_state_e;

  // Ideal ladder threshold code for a comparator, computed modulo 2^BITS
  function automatic logic [BITS-1:0] nom_code(input logic [IW-1:0] idx);
    logic [BITS-1:0] idxWide;
    idxWide = BITS'(idx);
    return NOM_BASE + idxWide * NOM_STEP;
  endfunction

  // Signed distance of a settled DAC code from the ideal threshold
  function automatic logic [OFF_W-1:0] code_offset(input logic [BITS-1:0] code,
                                                   input logic [IW-1:0]   idx);
    return {1'b0, code} - {1'b0, nom_code(idx)};
  endfunction

  // Two's complement less-than on offset-width values
  function automatic logic off_less(input logic [OFF_W-1:0] a,
                                    input logic [OFF_W-1:0] b);
    return $signed(a) < $signed(b);
  endfunction

endpackage

// File: rtl/cmp_offset_table.sv
// Per-comparator offset storage: one write port for captures and a
// registered read port whose output register directly drives the stream
// data. Only the read register is reset; the array keeps its contents.
module cmp_offset_table
  import cmp_cal_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             we_i,
  input  logic [IW-1:0]    waddr_i,
  input  logic [OFF_W-1:0] wdata_i,
  input  logic             re_i,
  input  logic [IW-1:0]    raddr_i,
  output logic [OFF_W-1:0] rdata_o
);

  logic [OFF_W-1:0] mem_q [N_CMP];
  logic [OFF_W-1:0] rdata_q;

  // Capture write: the array is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read register only moves on a read request so the stream can stall
  always_ff @(posedge clk) begin
    if (!rst_n || clear_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/cmp_offset_collector.sv
// Collects the offset finder's settled SAR DAC codes, one per comparator,
// turns them into signed offsets from the ideal ladder, tracks the extreme
// offsets and streams the finished table out over valid/ready.
module cmp_offset_collector
  import cmp_cal_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rdy,
  input  logic [BITS-1:0]  dac_ctl,
  input  logic             clear,
  input  logic             dump_req,
  output logic             done,
  output logic             err,
  output logic [OFF_W-1:0] min_off,
  output logic [OFF_W-1:0] max_off,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IW-1:0]    out_idx,
  output logic [OFF_W-1:0] out_offset
);

  cal_state_e       state_q, state_d;
  logic [IW-1:0]    idx_q;
  logic             rdy_q;
  logic             err_q;
  logic [OFF_W-1:0] minOff_q;
  logic [OFF_W-1:0] maxOff_q;
  logic [IW-1:0]    rdPtr_q;
  logic             outValid_q;
  logic [IW-1:0]    outIdx_q;

  logic             rise;
  logic [OFF_W-1:0] capOff;
  logic             capture;
  logic             load;
  logic             handshake;
  logic             lastOut;

  assign rise      = rdy & ~rdy_q;
  assign capOff    = code_offset(dac_ctl, idx_q);
  assign handshake = outValid_q & out_ready;
  assign lastOut   = (outIdx_q == LAST_IDX);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: clear overrides every other transition
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      COLLECT: if (rise && idx_q == LAST_IDX) state_d = DONE;
      DONE:    if (dump_req) state_d = DUMP;
      DUMP:    if (handshake && lastOut) state_d = DONE;
      default: state_d = COLLECT;
    endcase
    if (clear) begin
      state_d = COLLECT;
    end
  end

  // State-decoded controls: capture strobe, stream reload, done flag
  always_comb begin
    capture = 1'b0;
    load    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      COLLECT: capture = rise;
      DONE:    done = 1'b1;
      DUMP: begin
        done = 1'b1;
        load = ~outValid_q | (handshake & ~lastOut);
      end
      default: ;
    endcase
    if (clear) begin
      capture = 1'b0;
      load    = 1'b0;
    end
  end

  // Edge detector and capture index; the index wraps after the last comparator
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      rdy_q <= 1'b0;
      idx_q <= '0;
    end else begin
      rdy_q <= rdy;
      if (capture) begin
        idx_q <= idx_q + IW'(1);
      end
    end
  end

  // Sticky error: a finder strobe outside the collection phase
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      err_q <= 1'b0;
    end else if (rise && state_q != COLLECT) begin
      err_q <= 1'b1;
    end
  end

  // Min/max trackers start at the opposite extremes so the first capture wins both
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      minOff_q <= OFF_MOST_POS;
      maxOff_q <= OFF_MOST_NEG;
    end else if (capture) begin
      if (off_less(capOff, minOff_q)) begin
        minOff_q <= capOff;
      end
      if (off_less(maxOff_q, capOff)) begin
        maxOff_q <= capOff;
      end
    end
  end

  // Stream front end: rdPtr names the next entry to fetch into the output register
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      rdPtr_q    <= '0;
      outValid_q <= 1'b0;
      outIdx_q   <= '0;
    end else if (state_q != DUMP) begin
      rdPtr_q    <= '0;
      outValid_q <= 1'b0;
    end else if (load) begin
      rdPtr_q    <= rdPtr_q + IW'(1);
      outIdx_q   <= rdPtr_q;
      outValid_q <= 1'b1;
    end else if (handshake) begin
      outValid_q <= 1'b0;
    end
  end

  cmp_offset_table uTable (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (clear),
    .we_i    (capture),
    .waddr_i (idx_q),
    .wdata_i (capOff),
    .re_i    (load),
    .raddr_i (rdPtr_q),
    .rdata_o (out_offset)
  );

  assign err       = err_q;
  assign min_off   = minOff_q;
  assign max_off   = maxOff_q;
  assign out_valid = outValid_q;
  assign out_idx   = outIdx_q;

endmodule

// File: tb/tb_cmp_offset_collector.sv
// Directed bench for the comparator offset collector: capture campaigns,
// extreme tracking, error flagging, stalled and continuous dumps, and a
// clear that aborts a dump part way through.
module tb_cmp_offset_collector;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b0;
  logic [15:0] dac_ctl = 16'h0000;
  logic        clear = 1'b0;
  logic        dump_req = 1'b0;
  logic        done;
  logic        err;
  logic [16:0] min_off;
  logic [16:0] max_off;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  out_idx;
  logic [16:0] out_offset;

  int total = 0;
  int bad = 0;

  logic [15:0] stimCode [32];
  logic [16:0] expOffTab [32];

  always #5 clk = ~clk;

  cmp_offset_collector dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rdy        (rdy),
    .dac_ctl    (dac_ctl),
    .clear      (clear),
    .dump_req   (dump_req),
    .done       (done),
    .err        (err),
    .min_off    (min_off),
    .max_off    (max_off),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_idx    (out_idx),
    .out_offset (out_offset)
  );

  // Advance one clock and settle just past the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One finder strobe: rdy high for 'hold' cycles, then low for one
  task automatic applyStimulus(input logic [15:0] code, input int hold);
    dac_ctl = code;
    rdy = 1'b1;
    repeat (hold) tick();
    rdy = 1'b0;
    tick();
  endtask

  // Ideal ladder codes with zero expected offset everywhere
  task automatic loadIdeal();
    for (int k = 0; k < 32; k++) begin
      stimCode[k]  = 16'h0400 + 16'(k) * 16'h0800;
      expOffTab[k] = 17'h00000;
    end
  endtask

  task automatic runCampaign(input int startK, input int hold);
    for (int k = startK; k < 32; k++) begin
      applyStimulus(stimCode[k], hold);
      if (k == 30) checkOutput("doneBeforeLast", {31'd0, done}, 32'd1 - 32'd1);
    end
    checkOutput("doneAfterLast", {31'd0, done}, 32'd1);
  endtask

  // pattern 0: ready always high; pattern 1: ready 1,0,0,1 repeating.
  // abortAt >= 0 stops when that entry is presented and clears the block.
  task automatic runDump(input int pattern, input int abortAt);
    int got;
    bit stalled;
    logic [4:0]  holdIdx;
    logic [16:0] holdOff;
    got = 0;
    stalled = 0;
    holdIdx = '0;
    holdOff = '0;
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    checkOutput("dumpEntryValidLow", {31'd0, out_valid}, 32'd0);
    tick();
    for (int c = 0; c < 200 && got < 32; c++) begin
      if (abortAt >= 0 && got == abortAt) break;
      out_ready = (pattern == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
      checkOutput("dumpValid", {31'd0, out_valid}, 32'd1);
      if (stalled) begin
        checkOutput("stallIdx", {27'd0, out_idx}, {27'd0, holdIdx});
        checkOutput("stallOff", {15'd0, out_offset}, {15'd0, holdOff});
      end
      if (out_valid && out_ready) begin
        checkOutput("dumpIdx", {27'd0, out_idx}, got);
        checkOutput("dumpOff", {15'd0, out_offset}, {15'd0, expOffTab[got]});
        got++;
        stalled = 0;
      end else begin
        stalled = 1;
        holdIdx = out_idx;
        holdOff = out_offset;
      end
      tick();
    end
    out_ready = 1'b0;
    if (abortAt < 0) begin
      checkOutput("dumpCount", got, 32);
      checkOutput("dumpEndValid", {31'd0, out_valid}, 32'd0);
      checkOutput("dumpEndDone", {31'd0, done}, 32'd1);
    end else begin
      checkOutput("abortCount", got, abortAt);
      checkOutput("abortIdx", {27'd0, out_idx}, abortAt);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      checkOutput("abortValidLow", {31'd0, out_valid}, 32'd0);
      checkOutput("abortDoneLow", {31'd0, done}, 32'd0);
    end
  endtask

  initial begin
    // Reset
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("rstDone", {31'd0, done}, 32'd0);
    checkOutput("rstErr", {31'd0, err}, 32'd0);
    checkOutput("rstValid", {31'd0, out_valid}, 32'd0);
    checkOutput("rstIdx", {27'd0, out_idx}, 32'd0);
    checkOutput("rstOff", {15'd0, out_offset}, 32'd0);
    checkOutput("rstMin", {15'd0, min_off}, 32'h0000FFFF);
    checkOutput("rstMax", {15'd0, max_off}, 32'h00010000);

    // Campaign A: +16 on comparator 0, -16 on comparator 1, rdy held 5 cycles
    loadIdeal();
    stimCode[0]  = 16'h0410;
    expOffTab[0] = 17'h00010;
    stimCode[1]  = 16'h0BF0;
    expOffTab[1] = 17'h1FFF0;
    applyStimulus(stimCode[0], 5);
    checkOutput("aMin0", {15'd0, min_off}, 32'h00000010);
    checkOutput("aMax0", {15'd0, max_off}, 32'h00000010);
    applyStimulus(stimCode[1], 5);
    checkOutput("aMin1", {15'd0, min_off}, 32'h0001FFF0);
    checkOutput("aMax1", {15'd0, max_off}, 32'h00000010);
    checkOutput("aDoneEarly", {31'd0, done}, 32'd0);
    runCampaign(2, 5);
    checkOutput("aMinEnd", {15'd0, min_off}, 32'h0001FFF0);
    checkOutput("aMaxEnd", {15'd0, max_off}, 32'h00000010);
    checkOutput("aErr", {31'd0, err}, 32'd0);

    // Stalled dump of campaign A
    runDump(1, -1);

    // Extra strobe after completion flags an error and leaves the table alone
    applyStimulus(16'h1234, 1);
    checkOutput("extraErr", {31'd0, err}, 32'd1);
    checkOutput("extraDone", {31'd0, done}, 32'd1);
    runDump(0, -1);

    // Clear restarts the campaign
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checkOutput("clrErr", {31'd0, err}, 32'd0);
    checkOutput("clrDone", {31'd0, done}, 32'd0);
    checkOutput("clrMin", {15'd0, min_off}, 32'h0000FFFF);
    checkOutput("clrMax", {15'd0, max_off}, 32'h00010000);
    checkOutput("clrValid", {31'd0, out_valid}, 32'd0);

    // Campaign B: large negative, positive and top-of-range codes
    loadIdeal();
    stimCode[2]   = 16'h0000;
    expOffTab[2]  = 17'h1EC00;
    stimCode[5]   = 16'h2D00;
    expOffTab[5]  = 17'h00100;
    stimCode[31]  = 16'hFFFF;
    expOffTab[31] = 17'h003FF;
    runCampaign(0, 1);
    checkOutput("bMin", {15'd0, min_off}, 32'h0001EC00);
    checkOutput("bMax", {15'd0, max_off}, 32'h000003FF);

    // Dump B, aborted by clear while entry 10 is presented
    runDump(1, 10);

    // Campaign C after the abort must start from comparator 0
    loadIdeal();
    runCampaign(0, 2);
    checkOutput("cMin", {15'd0, min_off}, 32'd0);
    checkOutput("cMax", {15'd0, max_off}, 32'd0);
    checkOutput("cErr", {31'd0, err}, 32'd0);
    runDump(0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
